// File: rtl/pwm_ramp_sequencer.sv
// Register bank plus duty-cycle ramp engine sitting between the SPI decoder
// and the PWM peripheral. SPI writes to the duty register always win over
// the ramp engine and cancel any ramp in progress.
module pwm_ramp_sequencer #(
  parameter int PRESCALE = 256,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              busy,
  output logic              done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STEP, S_FINISH} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi;
  logic [7:0]      r_duty, r_target, r_step, r_hold, r_start;
  logic            r_bounce, r_done, w_done_next;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_ticks;

  logic            w_wr_duty, w_wr_ctrl, w_start, w_stop, w_abort, w_busy;
  logic            w_presc_wrap, w_hold_done, w_reached, w_swap, w_step_apply;
  logic [7:0]      w_step_eff, w_hold_eff, w_new_duty;
  logic [8:0]      w_ticks_inc;

  // Move cur toward tgt by stp, clamping at tgt; 9-bit math so nothing wraps.
  function automatic logic [7:0] f_step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] stp);
    logic [8:0] s;
    if (tgt > cur) begin
      s = {1'b0, cur} + {1'b0, stp};
      f_step_toward = (s > {1'b0, tgt}) ? tgt : s[7:0];
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      f_step_toward = (s[8] || (s[7:0] < tgt)) ? tgt : s[7:0];
    end
  endfunction

  assign w_wr_duty    = wr_valid && (wr_addr == ADDR_W'(4));
  assign w_wr_ctrl    = wr_valid && (wr_addr == ADDR_W'(8));
  assign w_start      = w_wr_ctrl && wr_data[0];
  assign w_stop       = w_wr_ctrl && !wr_data[0];
  assign w_busy       = (r_state != S_IDLE);
  assign w_abort      = w_busy && (w_wr_duty || w_stop);
  assign w_step_eff   = (r_step == 8'd0) ? 8'd1 : r_step;
  assign w_hold_eff   = (r_hold == 8'd0) ? 8'd1 : r_hold;
  assign w_presc_wrap = (r_presc == PW'(PRESCALE - 1));
  assign w_ticks_inc  = {1'b0, r_ticks} + 9'd1;
  assign w_hold_done  = w_presc_wrap && (w_ticks_inc == {1'b0, w_hold_eff});
  assign w_new_duty   = f_step_toward(r_duty, r_target, w_step_eff);
  assign w_reached    = (w_new_duty == r_target);
  assign w_step_apply = (r_state == S_STEP) && !w_abort;
  assign w_swap       = w_step_apply && w_reached && r_bounce;

  // Next-state and done-pulse decode for the ramp sequencer.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_target == r_duty) w_done_next  = 1'b1;
          else                    w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_abort)          w_state_next = S_IDLE;
        else if (w_hold_done) w_state_next = S_STEP;
      end
      S_STEP: begin
        if (w_abort)                     w_state_next = S_IDLE;
        else if (w_reached && !r_bounce) w_state_next = S_FINISH;
        else                             w_state_next = S_HOLD;
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
        w_done_next  = !w_abort;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sequencer state, done pulse, and prescaler/tick counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_presc <= '0;
      r_ticks <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      if (r_state == S_HOLD && w_state_next == S_HOLD) begin
        if (w_presc_wrap) begin
          r_presc <= '0;
          r_ticks <= w_ticks_inc[7:0];
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end else begin
        r_presc <= '0;
        r_ticks <= 8'd0;
      end
    end
  end

  // SPI register bank; duty and target also take ramp updates, SPI first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_lo <= 8'h00;
      r_out_hi <= 8'h00;
      r_pwm_lo <= 8'h00;
      r_pwm_hi <= 8'h00;
      r_duty   <= 8'h00;
      r_target <= 8'h00;
      r_step   <= 8'h00;
      r_hold   <= 8'h00;
    end else begin
      if (w_step_apply) r_duty   <= w_new_duty;
      if (w_swap)       r_target <= r_start;
      if (wr_valid) begin
        case (wr_addr)
          ADDR_W'(0): r_out_lo <= wr_data;
          ADDR_W'(1): r_out_hi <= wr_data;
          ADDR_W'(2): r_pwm_lo <= wr_data;
          ADDR_W'(3): r_pwm_hi <= wr_data;
          ADDR_W'(4): r_duty   <= wr_data;
          ADDR_W'(5): r_target <= wr_data;
          ADDR_W'(6): r_step   <= wr_data;
          ADDR_W'(7): r_hold   <= wr_data;
          default: ;
        endcase
      end
    end
  end

  // Ramp origin and bounce flag, latched on start and swapped at each bounce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start  <= 8'h00;
      r_bounce <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_start  <= r_duty;
      r_bounce <= wr_data[1];
    end else if (w_swap) begin
      r_start  <= r_target;
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign busy            = w_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed SPI writes, a per-cycle comparison
// against a countdown-based behavioural model, and literal spot checks.
module tb_pwm_ramp_sequencer;

  localparam int PRESC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_addr = 7'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty;
  logic       o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;
  int g_cyc    = 0;
  logic chk_en = 1'b0;

  // Model state
  logic [7:0] m_reg [0:3];
  logic [7:0] m_duty, m_tgt, m_step, m_hold, m_start;
  logic       m_busy, m_done, m_bounce, m_fin;
  int         m_cnt;

  pwm_ramp_sequencer #(.PRESCALE(PRESC), .ADDR_W(7)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .en_reg_out_7_0  (o_out_lo),
    .en_reg_out_15_8 (o_out_hi),
    .en_reg_pwm_7_0  (o_pwm_lo),
    .en_reg_pwm_15_8 (o_pwm_hi),
    .pwm_duty_cycle  (o_duty),
    .busy            (o_busy),
    .done            (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) g_cyc <= g_cyc + 1;

  function automatic int hold_cycles(input logic [7:0] h);
    return ((h == 8'd0) ? 1 : int'(h)) * PRESC + 1;
  endfunction

  // Behavioural model: a ramp is a countdown to the next duty change.
  always @(posedge clk) begin
    int stp, cur, tg, nd;
    logic [7:0] tmp;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_duty = 8'h00; m_tgt = 8'h00; m_step = 8'h00; m_hold = 8'h00;
      m_start = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_bounce = 1'b0;
      m_fin = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (wr_valid && (wr_addr == 7'd4 || (wr_addr == 7'd8 && !wr_data[0]))) begin
          m_busy = 1'b0;
          m_fin  = 1'b0;
        end else if (m_fin) begin
          m_busy = 1'b0;
          m_fin  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            stp = (m_step == 8'd0) ? 1 : int'(m_step);
            cur = int'(m_duty);
            tg  = int'(m_tgt);
            if (tg > cur) nd = (cur + stp > tg) ? tg : cur + stp;
            else          nd = (cur - stp < tg) ? tg : cur - stp;
            m_duty = 8'(nd);
            m_cnt  = hold_cycles(m_hold);
            if (nd == tg) begin
              if (m_bounce) begin
                tmp = m_tgt; m_tgt = m_start; m_start = tmp;
              end else begin
                m_fin = 1'b1;
              end
            end
          end
        end
      end else if (wr_valid && wr_addr == 7'd8 && wr_data[0]) begin
        if (m_tgt == m_duty) m_done = 1'b1;
        else begin
          m_busy   = 1'b1;
          m_start  = m_duty;
          m_bounce = wr_data[1];
          m_cnt    = hold_cycles(m_hold);
        end
      end
      if (wr_valid) begin
        case (wr_addr)
          7'd0, 7'd1, 7'd2, 7'd3: m_reg[wr_addr[1:0]] = wr_data;
          7'd4: m_duty = wr_data;
          7'd5: m_tgt  = wr_data;
          7'd6: m_step = wr_data;
          7'd7: m_hold = wr_data;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ({o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty, o_busy, o_done} !==
          {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_duty, m_busy, m_done}) begin
        n_fail++;
        $display("FAIL cycle%0d: got regs=%h %h %h %h duty=%h busy=%b done=%b, required regs=%h %h %h %h duty=%h busy=%b done=%b",
                 g_cyc, o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty, o_busy, o_done,
                 m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_duty, m_busy, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, output int t);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    t = g_cyc;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (g_cyc < t) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  initial begin
    int t, t2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_duty", o_duty, 8'h00);
    chk("reset_out_lo", o_out_lo, 8'h00);
    chk("reset_busy_done", {6'd0, o_busy, o_done}, 8'h00);

    // Register bank writes
    wr(7'h00, 8'hA5, t); wait_until(t + 1);
    chk("reg_out_lo", o_out_lo, 8'hA5);
    wr(7'h03, 8'h3C, t); wait_until(t + 1);
    chk("reg_pwm_hi", o_pwm_hi, 8'h3C);
    wr(7'h09, 8'hFF, t); wait_until(t + 1);
    chk("reg_ignore_lo", o_out_lo, 8'hA5);
    chk("reg_ignore_hi", o_out_hi, 8'h00);
    chk("reg_ignore_pwm_lo", o_pwm_lo, 8'h00);
    chk("reg_ignore_duty", o_duty, 8'h00);

    // Up-ramp 0x10 -> 0x20 step 8 hold 1
    wr(7'h04, 8'h10, t); wr(7'h05, 8'h20, t); wr(7'h06, 8'h08, t); wr(7'h07, 8'h01, t);
    wr(7'h08, 8'h01, t);
    wait_until(t + 1);  chk("up_busy_rise", {7'd0, o_busy}, 8'h01);
    wait_until(t + 5);  chk("up_duty_t5", o_duty, 8'h10);
    wait_until(t + 6);  chk("up_duty_t6", o_duty, 8'h18);
    wait_until(t + 11); chk("up_duty_t11", o_duty, 8'h20);
    chk("up_busy_t11", {7'd0, o_busy}, 8'h01);
    wait_until(t + 12); chk("up_done_t12", {6'd0, o_busy, o_done}, 8'h01);
    wait_until(t + 13); chk("up_done_t13", {7'd0, o_done}, 8'h00);

    // Saturating up-step 0xF0 -> 0xFF
    wr(7'h04, 8'hF0, t); wr(7'h05, 8'hFF, t); wr(7'h06, 8'h20, t);
    wr(7'h08, 8'h01, t);
    wait_until(t + 6); chk("sat_duty", o_duty, 8'hFF);
    wait_until(t + 7); chk("sat_done", {6'd0, o_busy, o_done}, 8'h01);

    // Down-ramp 0x80 -> 0x00 step 0x30
    wr(7'h04, 8'h80, t); wr(7'h05, 8'h00, t); wr(7'h06, 8'h30, t);
    wr(7'h08, 8'h01, t);
    wait_until(t + 6);  chk("down_1", o_duty, 8'h50);
    wait_until(t + 11); chk("down_2", o_duty, 8'h20);
    wait_until(t + 16); chk("down_3", o_duty, 8'h00);
    wait_until(t + 17); chk("down_done", {6'd0, o_busy, o_done}, 8'h01);

    // Bounce 0x40 <-> 0x48 step 4
    wr(7'h04, 8'h40, t); wr(7'h05, 8'h48, t); wr(7'h06, 8'h04, t);
    wr(7'h08, 8'h03, t);
    wait_until(t + 6);  chk("bounce_1", o_duty, 8'h44);
    wait_until(t + 11); chk("bounce_2", o_duty, 8'h48);
    wait_until(t + 16); chk("bounce_3", o_duty, 8'h44);
    wait_until(t + 21); chk("bounce_4", o_duty, 8'h40);
    wait_until(t + 26); chk("bounce_5", o_duty, 8'h44);
    wr(7'h08, 8'h00, t2);
    wait_until(t2 + 1);  chk("stop_busy", {7'd0, o_busy}, 8'h00);
    chk("stop_duty", o_duty, 8'h44);
    wait_until(t2 + 12); chk("stop_frozen", o_duty, 8'h44);

    // SPI duty write on the exact STEP cycle
    wr(7'h04, 8'h10, t); wr(7'h05, 8'h20, t); wr(7'h06, 8'h08, t);
    wr(7'h08, 8'h01, t);
    wait_until(t + 4);
    wr(7'h04, 8'h77, t2);
    chk("arb_on_step_cycle", 8'(t2 - t), 8'd5);
    wait_until(t2 + 1); chk("arb_duty", o_duty, 8'h77);
    chk("arb_busy_done", {6'd0, o_busy, o_done}, 8'h00);
    wait_until(t2 + 2); chk("arb_no_done", {6'd0, o_busy, o_done}, 8'h00);

    // Zero distance start
    wr(7'h05, 8'h77, t); wr(7'h08, 8'h01, t);
    wait_until(t + 1); chk("zero_done", {6'd0, o_busy, o_done}, 8'h01);
    wait_until(t + 2); chk("zero_after", {6'd0, o_busy, o_done}, 8'h00);

    // Reset mid-ramp
    wr(7'h05, 8'h90, t); wr(7'h08, 8'h01, t);
    wait_until(t + 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_duty", o_duty, 8'h00);
    chk("rst_regs", o_out_lo | o_pwm_hi, 8'h00);
    chk("rst_busy_done", {6'd0, o_busy, o_done}, 8'h00);
    repeat (20) @(negedge clk);
    chk("rst_quiet_duty", o_duty, 8'h00);
    chk("rst_quiet_busy", {6'd0, o_busy, o_done}, 8'h00);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
